// File: rtl/input_debounce.sv
// input_debounce: synchronizes and atomically debounces the 3-bit command code for fsm.user_input
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset
//   raw_in     - asynchronous, possibly bouncing command lines
//   glitch_clr - synchronous clear of glitch_cnt (wins over a same-edge increment)
//   user_input - debounced command code, all bits change together
//   changed    - one-cycle strobe registered on the commit edge
//   busy       - a code differing from user_input is in flight
//   glitch_cnt - saturating count of abandoned candidates
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] raw_in,
    input  logic       glitch_clr,
    output logic [2:0] user_input,
    output logic       changed,
    output logic       busy,
    output logic [7:0] glitch_cnt
);
    logic [2:0]       s1, s2, cand;
    logic [CNT_W-1:0] cnt;
    logic             diff, pend, done;

    assign diff = s2 != cand;
    assign pend = cand != user_input;
    assign done = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
    assign busy = (s2 != user_input) || pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            cnt        <= '0;
            user_input <= '0;
            changed    <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            s1      <= raw_in;
            s2      <= s1;
            changed <= 1'b0;
            // A new synchronized code always restarts qualification; the whole
            // vector is the candidate, so no partial code can ever commit.
            if (diff) begin
                cand <= s2;
                cnt  <= '0;
            end else if (pend) begin
                if (done) begin
                    user_input <= cand;
                    cnt        <= '0;
                    changed    <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            // Only candidates that would have changed the output count as glitches.
            if (glitch_clr)
                glitch_cnt <= '0;
            else if (diff && pend && glitch_cnt != 8'hff)
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed checks of input_debounce with DEBOUNCE_CYCLES=4 and =1
module tb_input_debounce;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw = '0, raw1 = '0;
    logic       glitch_clr = 1'b0;
    logic [2:0] ui, ui1;
    logic       changed, changed1, busy, busy1;
    logic [7:0] gc, gc1;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    input_debounce dut (
        .clk(clk), .rst_n(rst_n), .raw_in(raw), .glitch_clr(glitch_clr),
        .user_input(ui), .changed(changed), .busy(busy), .glitch_cnt(gc)
    );

    input_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .raw_in(raw1), .glitch_clr(glitch_clr),
        .user_input(ui1), .changed(changed1), .busy(busy1), .glitch_cnt(gc1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        raw = '0;
        raw1 = '0;
        glitch_clr = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int pulses;
        // reset state
        repeat (2) step();
        check("rst_ui", 32'(ui), 0);
        check("rst_changed", 32'(changed), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_gc", 32'(gc), 0);
        do_reset();

        // steady 101: commit at edge 6
        raw = 3'b101;
        for (int e = 0; e <= 5; e++) begin
            step();
            check($sformatf("t1_ui_e%0d", e), 32'(ui), 0);
            if (e == 0) check("t1_busy_e0", 32'(busy), 0);
            if (e == 1) check("t1_busy_e1", 32'(busy), 1);
        end
        step();
        check("t1_ui_e6", 32'(ui), 5);
        check("t1_changed_e6", 32'(changed), 1);
        check("t1_busy_e6", 32'(busy), 0);
        step();
        check("t1_changed_e7", 32'(changed), 0);
        check("t1_gc", 32'(gc), 0);

        // 011 for 3 samples then 110: goes straight to 110
        do_reset();
        raw = 3'b011;
        repeat (3) step();
        raw = 3'b110;
        for (int e = 3; e < 12; e++) begin
            step();
            check($sformatf("t2_no011_e%0d", e), 32'(ui == 3'b011), 0);
            if (e == 8) check("t2_ui_e8", 32'(ui), 0);
        end
        check("t2_ui", 32'(ui), 6);
        check("t2_gc", 32'(gc), 1);

        // 2-sample pulse of 111 returning to 000
        do_reset();
        raw = 3'b111;
        repeat (2) step();
        raw = 3'b000;
        pulses = 0;
        for (int e = 2; e < 12; e++) begin
            step();
            pulses += int'(changed);
        end
        check("t3_changed", pulses, 0);
        check("t3_ui", 32'(ui), 0);
        check("t3_gc", 32'(gc), 1);
        check("t3_busy", 32'(busy), 0);

        // asynchronous reset in the middle of a pending 010
        do_reset();
        raw = 3'b010;
        repeat (4) step();
        check("t4_busy_pre", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        raw = 3'b000;
        #1;
        check("t4_ui_async", 32'(ui), 0);
        check("t4_busy_async", 32'(busy), 0);
        check("t4_changed_async", 32'(changed), 0);
        check("t4_gc_async", 32'(gc), 0);
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int e = 0; e < 10; e++) begin
            step();
            pulses += int'(changed);
            check($sformatf("t4_ui_e%0d", e), 32'(ui), 0);
        end
        check("t4_changed", pulses, 0);
        check("t4_busy", 32'(busy), 0);

        // alternating 1-sample glitches saturate glitch_cnt
        do_reset();
        for (int i = 0; i < 600; i++) begin
            raw = (i % 2 == 0) ? 3'b111 : 3'b000;
            step();
        end
        check("t5_sat", 32'(gc), 255);
        for (int i = 0; i < 20; i++) begin
            raw = (i % 2 == 0) ? 3'b111 : 3'b000;
            step();
        end
        check("t5_hold", 32'(gc), 255);
        check("t5_ui", 32'(ui), 0);
        // clear held across two edges so one of them coincides with an increment
        glitch_clr = 1'b1;
        raw = 3'b111;
        step();
        check("t5_clr_a", 32'(gc), 0);
        raw = 3'b000;
        step();
        check("t5_clr_b", 32'(gc), 0);
        glitch_clr = 1'b0;
        raw = 3'b111;
        step();
        raw = 3'b000;
        step();
        check("t5_count_after", 32'(gc > 0 && gc < 3), 1);

        // DEBOUNCE_CYCLES=1: commit at edge 3
        do_reset();
        raw1 = 3'b100;
        pulses = 0;
        for (int e = 0; e <= 2; e++) begin
            step();
            check($sformatf("t6_ui_e%0d", e), 32'(ui1), 0);
        end
        step();
        pulses += int'(changed1);
        check("t6_ui_e3", 32'(ui1), 4);
        check("t6_changed_e3", 32'(changed1), 1);
        for (int e = 4; e < 10; e++) begin
            step();
            pulses += int'(changed1);
        end
        check("t6_pulses", pulses, 1);
        check("t6_ui_end", 32'(ui1), 4);
        check("t6_gc", 32'(gc1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
